// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word/register ids, ALU opcodes and the
// ID/EX control bundle carried alongside the operands.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic [3:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra
    } lc3b_aluop;

    typedef struct packed {
        lc3b_aluop aluop;
        lc3b_reg   dest;
        logic      load_regfile;
        logic      is_load;
        logic      use_imm;
        logic      sr1_used;
        logic      sr2_used;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// One ALU operand: picks EX/MEM, MEM/WB or the stored value and flags a
// load-use hazard when the producer in EX/MEM cannot be forwarded yet.
module operand_fwd
    import lc3b_types::*;
#(
    parameter bit FWD_MEM_EN = 1'b1,
    parameter bit FWD_WB_EN  = 1'b1
) (
    input  logic     occupied,
    input  logic     used,
    input  lc3b_reg  sr,
    input  lc3b_word stored,
    input  logic     mem_wr,
    input  logic     mem_is_load,
    input  lc3b_reg  mem_dest,
    input  lc3b_word mem_data,
    input  logic     wb_wr,
    input  lc3b_reg  wb_dest,
    input  lc3b_word wb_data,
    output lc3b_word value,
    output logic     hazard,
    output logic     wb_hit
);

    logic mem_hit;

    assign mem_hit = occupied & used & mem_wr & (mem_dest == sr);
    assign wb_hit  = FWD_WB_EN & occupied & used & wb_wr & (wb_dest == sr);
    // Without MEM forwarding every EX/MEM producer must drain through WB.
    assign hazard  = mem_hit & (mem_is_load | !FWD_MEM_EN);

    always_comb begin
        value = stored;
        if (FWD_MEM_EN && mem_hit && !mem_is_load)
            value = mem_data;
        else if (wb_hit)
            value = wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// LC-3b ID/EX pipeline register: holds one decoded instruction, forwards
// MEM/WB results into the ALU operands and stalls on load-use hazards.
module id_ex_stage
    import lc3b_types::*;
#(
    parameter bit FWD_MEM_EN = 1'b1,
    parameter bit FWD_WB_EN  = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  lc3b_aluop in_aluop,
    input  lc3b_reg   in_sr1,
    input  lc3b_reg   in_sr2,
    input  logic      in_sr1_used,
    input  logic      in_sr2_used,
    input  lc3b_word  in_sr1_data,
    input  lc3b_word  in_sr2_data,
    input  lc3b_word  in_imm,
    input  logic      in_use_imm,
    input  lc3b_reg   in_dest,
    input  logic      in_load_regfile,
    input  logic      in_is_load,
    input  logic      mem_wr,
    input  logic      mem_is_load,
    input  lc3b_reg   mem_dest,
    input  lc3b_word  mem_data,
    input  logic      wb_wr,
    input  lc3b_reg   wb_dest,
    input  lc3b_word  wb_data,
    input  logic      out_ready,
    output logic      out_valid,
    output lc3b_aluop aluop,
    output lc3b_word  alu_a,
    output lc3b_word  alu_b,
    output lc3b_reg   out_dest,
    output logic      out_load_regfile,
    output logic      out_is_load
);

    localparam int NUM_OPS = 2;

    id_ex_ctrl_t                 ctrl_q;
    logic                        occupied;
    lc3b_word                    imm_q;
    lc3b_reg  [NUM_OPS-1:0]      sr_q;
    lc3b_word [NUM_OPS-1:0]      opnd_q;
    lc3b_word [NUM_OPS-1:0]      fwd;
    logic     [NUM_OPS-1:0]      used, haz, wb_hit;
    lc3b_reg  [NUM_OPS-1:0]      in_sr;
    lc3b_word [NUM_OPS-1:0]      in_data;
    logic     [NUM_OPS-1:0]      in_used;
    logic                        capture, advance;

    assign used    = {ctrl_q.sr2_used & ~ctrl_q.use_imm, ctrl_q.sr1_used};
    assign in_sr   = {in_sr2, in_sr1};
    assign in_data = {in_sr2_data, in_sr1_data};
    assign in_used = {in_sr2_used, in_sr1_used};

    genvar g;
    generate
        for (g = 0; g < NUM_OPS; g++) begin : g_op
            operand_fwd #(.FWD_MEM_EN(FWD_MEM_EN), .FWD_WB_EN(FWD_WB_EN)) u_fwd (
                .occupied    (occupied),
                .used        (used[g]),
                .sr          (sr_q[g]),
                .stored      (opnd_q[g]),
                .mem_wr      (mem_wr),
                .mem_is_load (mem_is_load),
                .mem_dest    (mem_dest),
                .mem_data    (mem_data),
                .wb_wr       (wb_wr),
                .wb_dest     (wb_dest),
                .wb_data     (wb_data),
                .value       (fwd[g]),
                .hazard      (haz[g]),
                .wb_hit      (wb_hit[g])
            );
        end
    endgenerate

    assign out_valid = occupied & ~(|haz) & ~flush;
    assign in_ready  = ~occupied | (out_valid & out_ready);
    assign capture   = in_valid & in_ready & ~flush;
    assign advance   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occupied     <= 1'b0;
            ctrl_q       <= '0;
            ctrl_q.aluop <= alu_pass;
            imm_q        <= '0;
            sr_q         <= '0;
            opnd_q       <= '0;
        end else if (flush) begin
            occupied <= 1'b0;
        end else if (capture) begin
            occupied <= 1'b1;
            ctrl_q   <= '{aluop: in_aluop, dest: in_dest, load_regfile: in_load_regfile,
                          is_load: in_is_load, use_imm: in_use_imm,
                          sr1_used: in_sr1_used, sr2_used: in_sr2_used};
            imm_q    <= in_imm;
            sr_q     <= in_sr;
            // Regfile write in the same cycle as the read: take the new value.
            for (int i = 0; i < NUM_OPS; i++)
                opnd_q[i] <= (FWD_WB_EN && wb_wr && in_used[i] && wb_dest == in_sr[i])
                             ? wb_data : in_data[i];
        end else if (advance) begin
            occupied <= 1'b0;
        end else begin
            // Stalled: absorb WB writes so the operand survives the producer retiring.
            for (int i = 0; i < NUM_OPS; i++)
                if (wb_hit[i]) opnd_q[i] <= wb_data;
        end
    end

    assign aluop            = ctrl_q.aluop;
    assign alu_a            = fwd[0];
    assign alu_b            = ctrl_q.use_imm ? imm_q : fwd[1];
    assign out_dest         = ctrl_q.dest;
    assign out_load_regfile = out_valid & ctrl_q.load_regfile;
    assign out_is_load      = out_valid & ctrl_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a behavioural model
// of the held instruction and its forwarding rules.
module tb_id_ex_stage;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic      reset_n, flush, in_valid, in_ready;
    lc3b_aluop in_aluop, aluop;
    lc3b_reg   in_sr1, in_sr2, in_dest, mem_dest, wb_dest, out_dest;
    logic      in_sr1_used, in_sr2_used, in_use_imm, in_load_regfile, in_is_load;
    lc3b_word  in_sr1_data, in_sr2_data, in_imm, mem_data, wb_data, alu_a, alu_b;
    logic      mem_wr, mem_is_load, wb_wr, out_ready, out_valid;
    logic      out_load_regfile, out_is_load;

    int vectors = 0, miscompares = 0;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_sr1_used(in_sr1_used), .in_sr2_used(in_sr2_used),
        .in_sr1_data(in_sr1_data), .in_sr2_data(in_sr2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_dest(in_dest), .in_load_regfile(in_load_regfile),
        .in_is_load(in_is_load), .mem_wr(mem_wr), .mem_is_load(mem_is_load),
        .mem_dest(mem_dest), .mem_data(mem_data), .wb_wr(wb_wr), .wb_dest(wb_dest),
        .wb_data(wb_data), .out_ready(out_ready), .out_valid(out_valid), .aluop(aluop),
        .alu_a(alu_a), .alu_b(alu_b), .out_dest(out_dest),
        .out_load_regfile(out_load_regfile), .out_is_load(out_is_load)
    );

    // Model: the one instruction the stage is holding, if any.
    logic        m_occ;
    lc3b_aluop   m_op;
    logic [2:0]  m_sr[2];
    logic        m_used[2];
    logic [15:0] m_d[2];
    logic [15:0] m_imm;
    logic        m_use_imm, m_lr, m_ld;
    logic [2:0]  m_dest;

    logic        e_valid, e_ready;
    logic [15:0] e_a, e_b;

    function automatic logic live(int i);
        return m_occ && m_used[i] && !(i == 1 && m_use_imm);
    endfunction

    function automatic logic [15:0] operand(int i);
        if (live(i) && mem_wr && !mem_is_load && mem_dest == m_sr[i]) return mem_data;
        if (live(i) && wb_wr && wb_dest == m_sr[i]) return wb_data;
        return m_d[i];
    endfunction

    task automatic compute_exp();
        logic stall;
        stall = 1'b0;
        for (int i = 0; i < 2; i++)
            if (live(i) && mem_wr && mem_is_load && mem_dest == m_sr[i]) stall = 1'b1;
        e_valid = m_occ && !stall && !flush;
        e_ready = !m_occ || (e_valid && out_ready);
        e_a     = operand(0);
        e_b     = m_use_imm ? m_imm : operand(1);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Settle to the falling edge and compare every meaningful output.
    task automatic sample();
        #4;
        compute_exp();
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_load_regfile", 32'(out_load_regfile), 32'(e_valid && m_lr));
        chk("out_is_load", 32'(out_is_load), 32'(e_valid && m_ld));
        if (e_valid) begin
            chk("aluop", 32'(aluop), 32'(m_op));
            chk("alu_a", 32'(alu_a), 32'(e_a));
            chk("alu_b", 32'(alu_b), 32'(e_b));
            chk("out_dest", 32'(out_dest), 32'(m_dest));
        end
    endtask

    task automatic tick();
        logic [2:0]  isr[2];
        logic        iu[2];
        logic [15:0] idat[2];
        compute_exp();
        isr  = '{in_sr1, in_sr2};
        iu   = '{in_sr1_used, in_sr2_used};
        idat = '{in_sr1_data, in_sr2_data};
        if (!reset_n) begin
            m_occ = 0; m_op = alu_pass; m_imm = 0; m_use_imm = 0; m_lr = 0; m_ld = 0; m_dest = 0;
            for (int i = 0; i < 2; i++) begin m_sr[i] = 0; m_used[i] = 0; m_d[i] = 0; end
        end else if (flush) begin
            m_occ = 0;
        end else if (in_valid && e_ready) begin
            m_occ = 1; m_op = in_aluop; m_imm = in_imm; m_use_imm = in_use_imm;
            m_lr = in_load_regfile; m_ld = in_is_load; m_dest = in_dest;
            for (int i = 0; i < 2; i++) begin
                m_sr[i] = isr[i]; m_used[i] = iu[i];
                m_d[i]  = (wb_wr && iu[i] && wb_dest == isr[i]) ? wb_data : idat[i];
            end
        end else if (e_valid && out_ready) begin
            m_occ = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (live(i) && wb_wr && wb_dest == m_sr[i]) m_d[i] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset_n = 1; flush = 0; in_valid = 0; out_ready = 0;
        mem_wr = 0; mem_is_load = 0; mem_dest = 0; mem_data = 0;
        wb_wr = 0; wb_dest = 0; wb_data = 0;
    endtask

    task automatic set_instr(lc3b_aluop op, logic [2:0] s1, logic [15:0] d1, logic u1,
                             logic [2:0] s2, logic [15:0] d2, logic u2,
                             logic [15:0] imm, logic ui, logic [2:0] dst);
        in_valid = 1; in_aluop = op;
        in_sr1 = s1; in_sr1_data = d1; in_sr1_used = u1;
        in_sr2 = s2; in_sr2_data = d2; in_sr2_used = u2;
        in_imm = imm; in_use_imm = ui; in_dest = dst;
        in_load_regfile = 1; in_is_load = 0;
    endtask

    initial begin
        idle();
        set_instr(alu_add, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        reset_n = 0;
        tick();

        // Reset state
        idle(); sample();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_aluop", 32'(aluop), 32'(alu_pass));
        chk("rst_in_ready", 32'(in_ready), 1);
        tick();

        // Basic capture, 1-cycle latency
        set_instr(alu_add, 3'd1, 16'h0003, 1, 3'd0, 16'h0, 0, 16'h0004, 1, 3'd3);
        sample(); tick();
        idle(); sample();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_a", 32'(alu_a), 32'h0003);
        chk("add_b", 32'(alu_b), 32'h0004);
        chk("add_op", 32'(aluop), 32'(alu_add));
        chk("held_in_ready", 32'(in_ready), 0);
        tick();

        // Advance + capture same cycle, WB bypass at capture on sr2
        set_instr(alu_and, 3'd2, 16'h1111, 1, 3'd5, 16'h0000, 1, 16'h0, 0, 3'd4);
        out_ready = 1; wb_wr = 1; wb_dest = 3'd5; wb_data = 16'h00AA;
        sample();
        chk("swap_in_ready", 32'(in_ready), 1);
        tick();
        idle(); sample();
        chk("cap_a", 32'(alu_a), 32'h1111);
        chk("cap_wb_b", 32'(alu_b), 32'h00AA);
        tick();

        // MEM forward, then MEM over WB priority
        idle(); mem_wr = 1; mem_dest = 3'd2; mem_data = 16'h2222;
        sample();
        chk("mem_fwd_a", 32'(alu_a), 32'h2222);
        tick();
        wb_wr = 1; wb_dest = 3'd2; wb_data = 16'h3333;
        sample();
        chk("mem_prio_a", 32'(alu_a), 32'h2222);
        tick();

        // Load-use stall, refresh from WB, then release
        idle(); mem_wr = 1; mem_is_load = 1; mem_dest = 3'd2;
        sample();
        chk("lu_valid", 32'(out_valid), 0);
        chk("lu_in_ready", 32'(in_ready), 0);
        tick();
        idle(); wb_wr = 1; wb_dest = 3'd2; wb_data = 16'hBEEF;
        sample(); tick();
        idle(); sample();
        chk("lu_rel_valid", 32'(out_valid), 1);
        chk("lu_rel_a", 32'(alu_a), 32'hBEEF);
        tick();

        // Back-to-back, one per cycle
        for (int k = 0; k < 4; k++) begin
            idle(); out_ready = 1;
            set_instr(alu_sll, 3'(k), 16'(k), 1, 3'd7, 16'h0, 1, 16'(16'h0100 + k), 1, 3'(k));
            sample();
            if (k > 0) begin
                chk("b2b_valid", 32'(out_valid), 1);
                chk("b2b_b", 32'(alu_b), 32'(16'h0100 + k - 1));
            end
            tick();
        end
        // Back-pressure: outputs stable
        for (int k = 0; k < 2; k++) begin
            idle();
            set_instr(alu_srl, 3'd1, 16'h5555, 1, 3'd1, 16'h0, 0, 16'h0200, 1, 3'd6);
            sample();
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_b", 32'(alu_b), 32'h0103);
            chk("bp_valid", 32'(out_valid), 1);
            tick();
        end

        // Flush with held and incoming instruction
        flush = 1; out_ready = 1;
        sample();
        chk("fl_valid_now", 32'(out_valid), 0);
        tick();
        idle(); sample();
        chk("fl_valid_next", 32'(out_valid), 0);
        chk("fl_lr_next", 32'(out_load_regfile), 0);
        tick();

        // Reset during a stall
        set_instr(alu_not, 3'd3, 16'h0F0F, 1, 3'd0, 16'h0, 0, 16'h0, 1, 3'd1);
        sample(); tick();
        idle(); mem_wr = 1; mem_is_load = 1; mem_dest = 3'd3;
        sample();
        chk("rs_stall", 32'(out_valid), 0);
        reset_n = 0;
        tick();
        idle(); sample();
        chk("rs_aluop", 32'(aluop), 32'(alu_pass));
        chk("rs_valid", 32'(out_valid), 0);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n     = ($urandom_range(0, 99) >= 2);
            flush       = ($urandom_range(0, 99) < 5);
            in_valid    = ($urandom_range(0, 99) < 70);
            out_ready   = ($urandom_range(0, 99) < 75);
            in_aluop    = lc3b_aluop'($urandom_range(0, 6));
            in_sr1      = 3'($urandom_range(0, 3));
            in_sr2      = 3'($urandom_range(0, 3));
            in_sr1_used = 1'($urandom);
            in_sr2_used = 1'($urandom);
            in_sr1_data = 16'($urandom);
            in_sr2_data = 16'($urandom);
            in_imm      = 16'($urandom);
            in_use_imm  = 1'($urandom);
            in_dest     = 3'($urandom);
            in_load_regfile = 1'($urandom);
            in_is_load  = 1'($urandom);
            mem_wr      = 1'($urandom);
            mem_is_load = ($urandom_range(0, 99) < 30);
            mem_dest    = 3'($urandom_range(0, 3));
            mem_data    = 16'($urandom);
            wb_wr       = 1'($urandom);
            wb_dest     = 3'($urandom_range(0, 3));
            wb_data     = 16'($urandom);
            sample();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
